rvfpm_issue_ctrl: RTL and testbench

- In-order issue/commit scheduler between the CORE-V-XIF offload port and the rvfpm FPU core.
- Buffers offloaded FP instructions with their XIF id and waits for the core's commit or kill.
- Dispatches one committed instruction at a time to the FPU, then returns the completion id to the core through a valid/ready handshake.

---
 rtl/rvfpm_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_rvfpm_issue_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_issue_ctrl.sv
// In-order issue/commit scheduler between the CORE-V-XIF offload port and the rvfpm FPU.
// Offloaded instructions wait in a circular queue for commit/kill, then go to the FPU one at a time.
module rvfpm_issue_ctrl #(
    parameter int X_ID_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [31:0]                   issue_instr,
    input  logic [X_ID_WIDTH-1:0]         issue_id,
    input  logic                          commit_valid,
    input  logic [X_ID_WIDTH-1:0]         commit_id,
    input  logic                          commit_kill,
    input  logic                          fpu_ready,
    output logic                          fpu_enable,
    output logic [31:0]                   fpu_instr,
    output logic [X_ID_WIDTH-1:0]         fpu_id,
    input  logic                          fpu_done,
    input  logic [X_ID_WIDTH-1:0]         fpu_done_id,
    output logic                          result_valid,
    output logic [X_ID_WIDTH-1:0]         result_id,
    input  logic                          result_ready,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic                          err_protocol
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rvfpm_issue_ctrl: QUEUE_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic                  committed;
        logic                  killed;
    } entry_t;

    entry_t                 ent [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] ent_vld;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    state_t                 state;
    logic [X_ID_WIDTH-1:0]  inflight_id;

    entry_t head;
    logic   head_vld;
    logic   push;
    logic   pop_kill;
    logic   dispatch;
    logic   pop;
    logic   dup_hit;
    logic   commit_new;

    assign head     = ent[rd_ptr];
    assign head_vld = ent_vld[rd_ptr];

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign issue_ready = (queue_count < CW'(QUEUE_DEPTH));
    assign push        = issue_valid && issue_ready;

    assign pop_kill = (state == IDLE) && head_vld && head.committed && head.killed;
    assign dispatch = (state == IDLE) && head_vld && head.committed && !head.killed && fpu_ready;
    assign pop      = pop_kill || dispatch;

    // A commit for the id being issued this cycle lands on the incoming entry.
    assign commit_new = commit_valid && (commit_id == issue_id);

    always_comb begin
        dup_hit = (state == BUSY) && (inflight_id == issue_id);
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (ent_vld[i] && ent[i].id == issue_id) dup_hit = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) ent[i] <= '0;
            ent_vld      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            queue_count  <= '0;
            state        <= IDLE;
            inflight_id  <= '0;
            fpu_enable   <= 1'b0;
            fpu_instr    <= '0;
            fpu_id       <= '0;
            result_valid <= 1'b0;
            result_id    <= '0;
            err_protocol <= 1'b0;
        end else begin
            fpu_enable <= 1'b0;

            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (commit_valid && ent_vld[i] && ent[i].id == commit_id) begin
                    ent[i].committed <= 1'b1;
                    ent[i].killed    <= commit_kill;
                end
            end

            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end

            if (push) begin
                ent[wr_ptr]     <= '{issue_instr, issue_id, commit_new, commit_new && commit_kill};
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
                if (dup_hit) err_protocol <= 1'b1;
            end

            queue_count <= queue_count + CW'(push) - CW'(pop);

            if (fpu_done && state != BUSY) err_protocol <= 1'b1;

            case (state)
                IDLE: begin
                    if (dispatch) begin
                        fpu_enable  <= 1'b1;
                        fpu_instr   <= head.instr;
                        fpu_id      <= head.id;
                        inflight_id <= head.id;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (fpu_done) begin
                        result_valid <= 1'b1;
                        result_id    <= fpu_done_id;
                        state        <= RESP;
                        if (fpu_done_id != inflight_id) err_protocol <= 1'b1;
                    end
                end
                RESP: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Bench for rvfpm_issue_ctrl: directed scenarios, then random traffic checked by a
// scoreboard fed from an in-order commit/kill reference model.
module tb_rvfpm_issue_ctrl;
    localparam int IDW    = 4;
    localparam int DEPTH  = 4;
    localparam int N_RAND = 150;

    logic            ck = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [31:0]     issue_instr = '0;
    logic [IDW-1:0]  issue_id = '0;
    logic            commit_valid = 1'b0;
    logic [IDW-1:0]  commit_id = '0;
    logic            commit_kill = 1'b0;
    logic            fpu_ready = 1'b0;
    logic            fpu_enable;
    logic [31:0]     fpu_instr;
    logic [IDW-1:0]  fpu_id;
    logic            fpu_done = 1'b0;
    logic [IDW-1:0]  fpu_done_id = '0;
    logic            result_valid;
    logic [IDW-1:0]  result_id;
    logic            result_ready = 1'b0;
    logic [2:0]      queue_count;
    logic            err_protocol;

    rvfpm_issue_ctrl #(.X_ID_WIDTH(IDW), .QUEUE_DEPTH(DEPTH)) dut (
        .ck(ck), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_id(issue_id),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .fpu_ready(fpu_ready), .fpu_enable(fpu_enable), .fpu_instr(fpu_instr), .fpu_id(fpu_id),
        .fpu_done(fpu_done), .fpu_done_id(fpu_done_id),
        .result_valid(result_valid), .result_id(result_id), .result_ready(result_ready),
        .queue_count(queue_count), .err_protocol(err_protocol)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [31:0]    instr;
        logic [IDW-1:0] id;
        bit             committed;
        bit             killed;
    } m_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: issued-but-unresolved instructions in program order, and what must follow.
    m_t             mlist[$];
    m_t             exp_disp[$];
    logic [IDW-1:0] exp_res[$];
    logic [IDW-1:0] fpu_q[$];
    int             fpu_lat = 0;
    int             n_acc = 0;
    bit             stop = 0;
    logic [IDW-1:0] seen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; issue_valid = 1'b0; commit_valid = 1'b0; commit_kill = 1'b0;
        fpu_done = 1'b0; fpu_ready = 1'b0; result_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fpu_enable"}, 32'(fpu_enable), 0);
        check({tag, "_fpu_id"}, 32'(fpu_id), 0);
        check({tag, "_fpu_instr"}, fpu_instr, 0);
        check({tag, "_result_valid"}, 32'(result_valid), 0);
        check({tag, "_result_id"}, 32'(result_id), 0);
        check({tag, "_queue_count"}, 32'(queue_count), 0);
        check({tag, "_err"}, 32'(err_protocol), 0);
    endtask

    // Behaves as an always-ready FPU/core pair, returning each dispatched id the next cycle.
    task automatic run_drain(input int max_c);
        bit             pend;
        logic [IDW-1:0] pid;
        pend = 0; pid = '0;
        fpu_ready = 1'b1; result_ready = 1'b1;
        for (int c = 0; c < max_c; c++) begin
            fpu_done = pend; fpu_done_id = pid; pend = 0;
            tick();
            if (fpu_enable) begin
                seen.push_back(fpu_id);
                pend = 1; pid = fpu_id;
            end
        end
        fpu_done = 1'b0; result_ready = 1'b0;
    endtask

    task automatic issue_one(input logic [IDW-1:0] id, input logic [31:0] instr);
        issue_valid = 1'b1; issue_id = id; issue_instr = instr;
    endtask

    task automatic commit_one(input logic [IDW-1:0] id, input logic kill);
        commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    endtask

    initial begin
        int en_cnt;
        int bad;

        // Reset state and basic flow
        do_reset();
        check_zero("reset");
        issue_one(4'd3, 32'h00A57053); tick(); issue_valid = 1'b0;
        check("basic_count1", 32'(queue_count), 1);
        commit_one(4'd3, 1'b0); fpu_ready = 1'b1; tick(); commit_valid = 1'b0;
        check("basic_no_early_enable", 32'(fpu_enable), 0);
        tick();
        check("basic_enable", 32'(fpu_enable), 1);
        check("basic_fpu_id", 32'(fpu_id), 3);
        check("basic_fpu_instr", fpu_instr, 32'h00A57053);
        check("basic_count0", 32'(queue_count), 0);
        tick();
        check("basic_enable_pulse", 32'(fpu_enable), 0);
        check("basic_fpu_id_hold", 32'(fpu_id), 3);
        fpu_done = 1'b1; fpu_done_id = 4'd3; tick(); fpu_done = 1'b0;
        check("basic_result_valid", 32'(result_valid), 1);
        check("basic_result_id", 32'(result_id), 3);
        result_ready = 1'b1; tick(); result_ready = 1'b0;
        check("basic_result_drop", 32'(result_valid), 0);
        check("basic_err", 32'(err_protocol), 0);

        // Fill, refuse on full, and accept the cycle after a pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_one(IDW'(i), $urandom); tick();
        end
        issue_one(4'd4, 32'h1234_5678);
        check("fill_count4", 32'(queue_count), 4);
        check("fill_ready0", 32'(issue_ready), 0);
        tick();
        check("fill_fifth_refused", 32'(queue_count), 4);
        commit_one(4'd0, 1'b0); fpu_ready = 1'b1; tick(); commit_valid = 1'b0;
        check("fill_commit_refused", 32'(queue_count), 4);
        tick();
        check("fill_dispatch0", 32'(fpu_enable), 1);
        check("fill_dispatch0_id", 32'(fpu_id), 0);
        check("fill_pop_refused", 32'(queue_count), 3);
        check("fill_ready_back", 32'(issue_ready), 1);
        tick(); issue_valid = 1'b0;
        check("fill_accept_after_pop", 32'(queue_count), 4);
        fpu_done = 1'b1; fpu_done_id = 4'd0; tick(); fpu_done = 1'b0;
        check("fill_result_id", 32'(result_id), 0);

        // Kill skip
        do_reset();
        for (int i = 5; i <= 7; i++) begin
            issue_one(IDW'(i), 32'h100 + 32'(i)); tick();
        end
        issue_valid = 1'b0;
        commit_one(4'd6, 1'b1); tick();
        commit_one(4'd5, 1'b0); tick();
        commit_one(4'd7, 1'b0); tick();
        commit_valid = 1'b0;
        seen.delete();
        run_drain(40);
        check("kill_n_dispatch", 32'(seen.size()), 2);
        check("kill_first", 32'(seen[0]), 5);
        check("kill_second", 32'(seen[1]), 7);
        check("kill_count0", 32'(queue_count), 0);

        // In-order stall behind an uncommitted head
        do_reset();
        issue_one(4'd1, 32'hA1); tick();
        issue_one(4'd2, 32'hA2); tick();
        issue_valid = 1'b0;
        commit_one(4'd2, 1'b0); tick(); commit_valid = 1'b0;
        fpu_ready = 1'b1;
        en_cnt = 0;
        repeat (20) begin
            tick();
            if (fpu_enable) en_cnt++;
        end
        check("stall_no_dispatch", 32'(en_cnt), 0);
        commit_one(4'd1, 1'b0); tick(); commit_valid = 1'b0;
        seen.delete();
        run_drain(30);
        check("stall_n_dispatch", 32'(seen.size()), 2);
        check("stall_first", 32'(seen[0]), 1);
        check("stall_second", 32'(seen[1]), 2);

        // Backpressure, id mismatch, same-cycle issue+commit
        do_reset();
        fpu_ready = 1'b1;
        issue_one(4'd4, 32'hB4); commit_one(4'd4, 1'b0); tick();
        issue_one(4'd8, 32'hB8); commit_one(4'd8, 1'b0); tick();
        issue_valid = 1'b0; commit_valid = 1'b0;
        check("bp_dispatch4", 32'(fpu_enable), 1);
        check("bp_dispatch4_id", 32'(fpu_id), 4);
        fpu_done = 1'b1; fpu_done_id = 4'd9; tick(); fpu_done = 1'b0;
        check("bp_result_valid", 32'(result_valid), 1);
        check("bp_result_id", 32'(result_id), 9);
        check("bp_err_mismatch", 32'(err_protocol), 1);
        en_cnt = 0; bad = 0;
        repeat (5) begin
            tick();
            if (fpu_enable) en_cnt++;
            if (!result_valid || result_id != 4'd9) bad++;
        end
        check("bp_no_dispatch", 32'(en_cnt), 0);
        check("bp_result_stable", 32'(bad), 0);
        result_ready = 1'b1; tick(); result_ready = 1'b0;
        check("bp_result_drop", 32'(result_valid), 0);
        tick();
        check("bp_dispatch8", 32'(fpu_enable), 1);
        check("bp_dispatch8_id", 32'(fpu_id), 8);
        check("bp_err_sticky", 32'(err_protocol), 1);

        // Duplicate issue and stray completion
        do_reset();
        issue_one(4'd2, 32'hC2); tick(); tick(); issue_valid = 1'b0;
        check("dup_count", 32'(queue_count), 2);
        check("dup_err", 32'(err_protocol), 1);
        do_reset();
        fpu_done = 1'b1; fpu_done_id = 4'd1; tick(); fpu_done = 1'b0;
        check("stray_done_err", 32'(err_protocol), 1);
        check("stray_done_no_result", 32'(result_valid), 0);

        // Reset while BUSY with two entries queued
        do_reset();
        fpu_ready = 1'b1;
        issue_one(4'd10, 32'hD0); commit_one(4'd10, 1'b0); tick(); commit_valid = 1'b0;
        issue_one(4'd11, 32'hD1); tick();
        issue_one(4'd12, 32'hD2); tick();
        issue_valid = 1'b0;
        check("midrst_count2", 32'(queue_count), 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero("midrst");
        fpu_done = 1'b1; fpu_done_id = 4'd10; tick(); fpu_done = 1'b0; tick();
        check("midrst_late_done", 32'(result_valid), 0);
        check("midrst_no_dispatch", 32'(fpu_enable), 0);

        // Random traffic with scoreboard
        do_reset();
        fork
            begin : driver
                bit  finished;
                int  cand[$];
                int  k;
                m_t  e;
                finished = 0;
                for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
                    tick();
                    fpu_done = 1'b0;
                    fpu_ready = ($urandom_range(0, 3) != 0);
                    if (fpu_q.size() > 0) begin
                        if (fpu_lat == 0) begin
                            fpu_done = 1'b1;
                            fpu_done_id = fpu_q.pop_front();
                        end else begin
                            fpu_lat--;
                        end
                    end
                    result_ready = ($urandom_range(0, 2) != 0);
                    issue_valid = 1'b0; commit_valid = 1'b0; commit_kill = 1'b0;
                    if (n_acc < N_RAND && $urandom_range(0, 1) == 1) begin
                        issue_one(IDW'(n_acc), $urandom);
                        if (issue_ready) begin
                            mlist.push_back('{issue_instr, issue_id, 1'b0, 1'b0});
                            n_acc++;
                        end
                    end
                    if (n_acc >= N_RAND || $urandom_range(0, 2) == 0) begin
                        cand.delete();
                        for (int j = 0; j < mlist.size(); j++)
                            if (!mlist[j].committed) cand.push_back(j);
                        if (cand.size() > 0) begin
                            k = cand[$urandom_range(0, cand.size() - 1)];
                            commit_one(mlist[k].id, ($urandom_range(0, 3) == 0));
                            mlist[k].committed = 1;
                            mlist[k].killed = commit_kill;
                        end
                    end
                    // Only the oldest instruction may leave; killed ones vanish, committed ones dispatch.
                    while (mlist.size() > 0 && mlist[0].committed) begin
                        e = mlist.pop_front();
                        if (!e.killed) exp_disp.push_back(e);
                    end
                    finished = (n_acc >= N_RAND) && mlist.size() == 0 && exp_disp.size() == 0 &&
                               exp_res.size() == 0 && fpu_q.size() == 0 && !result_valid;
                end
                issue_valid = 1'b0; commit_valid = 1'b0; fpu_done = 1'b0; result_ready = 1'b0;
                if (!finished) begin
                    n_tests++; n_fail++;
                    $display("FAIL rand_drain_timeout: %0d dispatches and %0d results still pending",
                             exp_disp.size(), exp_res.size());
                end
                repeat (8) tick();
                stop = 1;
            end
            begin : monitor
                bit             prev_hold;
                logic [IDW-1:0] prev_rid;
                m_t             e;
                prev_hold = 0; prev_rid = '0;
                while (!stop) begin
                    @(negedge ck);
                    if (fpu_enable) begin
                        if (exp_disp.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL rand_dispatch: got unexpected fpu_id=%0d, expected no dispatch", fpu_id);
                        end else begin
                            e = exp_disp.pop_front();
                            check("rand_fpu_id", 32'(fpu_id), 32'(e.id));
                            check("rand_fpu_instr", fpu_instr, e.instr);
                            exp_res.push_back(e.id);
                            fpu_q.push_back(e.id);
                            fpu_lat = $urandom_range(0, 3);
                        end
                    end
                    if (prev_hold) begin
                        check("rand_result_hold_valid", 32'(result_valid), 1);
                        check("rand_result_hold_id", 32'(result_id), 32'(prev_rid));
                    end
                    if (result_valid && result_ready) begin
                        if (exp_res.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL rand_result: got unexpected result_id=%0d, expected none", result_id);
                        end else begin
                            check("rand_result_id", 32'(result_id), 32'(exp_res.pop_front()));
                        end
                    end
                    prev_hold = result_valid && !result_ready;
                    prev_rid = result_id;
                end
            end
        join
        check("rand_final_count", 32'(queue_count), 0);
        check("rand_final_err", 32'(err_protocol), 0);
        check("rand_final_result_valid", 32'(result_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
